// File: rtl/rotate_sequencer.sv
// Rotation-select sequencer for the four-digit HEX rotate display: a prescaled
// timer advances a 2-bit select, with pause, direction, single-step and load.
module rotate_sequencer #(
    parameter int DIV   = 50000000,
    parameter int CNT_W = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step_n,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] sel,
    output logic       tick,
    output logic       advance
);

    // Level inputs share one 2-flop synchronizer: {run, dir, load, load_val}
    logic [4:0] lvl_meta_q, lvl_s_q;
    // step_n chain: [0] meta, [1] synchronized, [2] previous for edge detect
    logic [2:0] step_q;

    logic             run_s, dir_s, load_s;
    logic [1:0]       load_val_s;
    logic             step_req;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             tick_q, tick_d;
    logic             advance_q, advance_d;
    logic             wrap;
    logic             do_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_meta_q <= '0;
            lvl_s_q    <= '0;
            step_q     <= '1;
        end else begin
            lvl_meta_q <= {run, dir, load, load_val};
            lvl_s_q    <= lvl_meta_q;
            step_q     <= {step_q[1:0], step_n};
        end
    end

    assign {run_s, dir_s, load_s, load_val_s} = lvl_s_q;
    assign step_req = step_q[2] & ~step_q[1];

    always_comb begin
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        tick_d    = 1'b0;
        advance_d = 1'b0;
        wrap      = 1'b0;
        do_step   = 1'b0;

        if (load_s) begin
            cnt_d = '0;
            sel_d = load_val_s;
        end else begin
            // Pausing holds the count so resume finishes the current interval
            if (run_s) begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            do_step = wrap | (step_req & ~run_s);
            if (do_step) begin
                sel_d     = dir_s ? sel_q - 2'd1 : sel_q + 2'd1;
                advance_d = 1'b1;
                tick_d    = wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            sel_q     <= 2'b00;
            tick_q    <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            tick_q    <= tick_d;
            advance_q <= advance_d;
        end
    end

    assign sel     = sel_q;
    assign tick    = tick_q;
    assign advance = advance_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Bench for rotate_sequencer (DIV=4): directed scenarios plus random inputs,
// checked every cycle against a behavioural model built from input history.
module tb_rotate_sequencer;
    localparam int DIV   = 4;
    localparam int CNT_W = 3;

    logic       clk, reset_n, run, dir, step_n, load;
    logic [1:0] load_val, sel;
    logic       tick, advance;

    int total = 0;
    int bad   = 0;

    rotate_sequencer #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .step_n(step_n),
        .load(load), .load_val(load_val), .sel(sel), .tick(tick), .advance(advance)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: logic acts on inputs as they were two edges earlier; a step
    // request is a 1->0 change between the inputs three and two edges back.
    typedef struct packed {
        logic       run, dir, load;
        logic [1:0] lv;
        logic       step_n;
    } in_t;

    localparam in_t IN_RST = '{run: 1'b0, dir: 1'b0, load: 1'b0, lv: 2'd0, step_n: 1'b1};

    in_t h1, h2, h3;
    int  m_cnt, m_sel;
    bit  m_tick, m_adv;

    always @(posedge clk or negedge reset_n) begin
        bit wrap, stp;
        if (!reset_n) begin
            h1 = IN_RST; h2 = IN_RST; h3 = IN_RST;
            m_cnt = 0; m_sel = 0; m_tick = 0; m_adv = 0;
        end else begin
            m_tick = 0;
            m_adv  = 0;
            if (h2.load) begin
                m_cnt = 0;
                m_sel = h2.lv;
            end else begin
                wrap = 0;
                if (h2.run) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DIV) begin
                        m_cnt = 0;
                        wrap  = 1;
                    end
                end
                stp = h3.step_n && !h2.step_n && !h2.run;
                if (wrap || stp) begin
                    m_sel  = (m_sel + (h2.dir ? 3 : 1)) % 4;
                    m_adv  = 1;
                    m_tick = wrap;
                end
            end
            h3 = h2;
            h2 = h1;
            h1 = '{run: run, dir: dir, load: load, lv: load_val, step_n: step_n};
        end
    end

    always @(negedge clk) begin
        chk("sel", sel, m_sel);
        chk("tick", tick, m_tick);
        chk("advance", advance, m_adv);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Measures cycles between consecutive ticks, bounded
    task automatic gap_check(input string tag, input int exp);
        int n;
        n = 0;
        while (!tick && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_first"}, int'(n < 50), 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 50);
        chk(tag, n, exp);
    endtask

    task automatic count_window(input int n, output int ticks, output int advs);
        ticks = 0; advs = 0;
        repeat (n) begin
            @(negedge clk);
            ticks += int'(tick);
            advs  += int'(advance);
        end
    endtask

    initial begin
        int tk, av;
        reset_n = 1'b0; run = 1'b0; dir = 1'b0; step_n = 1'b1;
        load = 1'b0; load_val = 2'd0;
        cycles(3);
        reset_n = 1'b1;

        // auto increment with wrap
        run = 1'b1;
        gap_check("inc_gap", DIV);
        gap_check("inc_gap2", DIV);
        cycles(10);

        // auto decrement; dir flipped mid-interval keeps spacing
        dir = 1'b1;
        gap_check("dec_gap", DIV);
        cycles(1);
        dir = 1'b0;
        gap_check("dirflip_gap", DIV);
        dir = 1'b1;
        cycles(9);

        // pause/resume
        run = 1'b0;
        cycles(3);
        count_window(20, tk, av);
        chk("pause_ticks", tk, 0);
        chk("pause_adv", av, 0);
        run = 1'b1;
        cycles(12);

        // single step held low while paused
        run = 1'b0; dir = 1'b0;
        cycles(4);
        step_n = 1'b0;
        count_window(10, tk, av);
        chk("step_adv", av, 1);
        chk("step_tick", tk, 0);
        step_n = 1'b1;
        cycles(3);
        run = 1'b1;
        cycles(5);
        step_n = 1'b0;
        cycles(3);
        step_n = 1'b1;
        cycles(8);

        // load holds select and suppresses ticks
        load = 1'b1; load_val = 2'd2;
        cycles(3);
        count_window(12, tk, av);
        chk("load_ticks", tk, 0);
        chk("load_adv", av, 0);
        chk("load_sel", sel, 2);

        // async reset mid-cycle while sel = 10
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_tick", tick, 0);
        chk("rst_adv", advance, 0);
        cycles(3);
        chk("rst_hold_sel", sel, 0);
        reset_n = 1'b1;
        cycles(6);
        load = 1'b0;
        cycles(12);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) load = ~load;
            if ($urandom_range(0, 9) == 0) load_val = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_n = ~step_n;
            if ($urandom_range(0, 199) == 0) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
